// File: rtl/lfsr_prbs_gen.sv
// Parameterised LFSR PRBS generator: Fibonacci or Galois form, OUTPUT_WIDTH
// steps per enabled cycle, optional bit reversal and inversion of the word.
module lfsr_prbs_gen #(
  parameter int unsigned           LFSR_WIDTH   = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = LFSR_WIDTH'(31'h10000001),
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT    = {LFSR_WIDTH{1'b1}},
  parameter string                 LFSR_CONFIG  = "FIBONACCI",
  parameter bit                    REVERSE      = 1'b0,
  parameter bit                    INVERT       = 1'b1,
  parameter int unsigned           OUTPUT_WIDTH = 8,
  parameter string                 STYLE        = "AUTO"
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic [OUTPUT_WIDTH-1:0] data_out
);

  localparam bit IS_GALOIS = (LFSR_CONFIG == "GALOIS");
  // STYLE only picks how the Fibonacci feedback parity is written.
  localparam bit USE_LOOP  = (STYLE == "LOOP");
  // Bit k selects s[k] into the Fibonacci feedback for polynomial term x^(k+1).
  localparam logic [LFSR_WIDTH-1:0] FIB_TAPS = {1'b0, LFSR_POLY[LFSR_WIDTH-1:1]};

  logic [LFSR_WIDTH-1:0]   state_q, state_d;
  logic [OUTPUT_WIDTH-1:0] data_q, data_d;

  logic [LFSR_WIDTH-1:0]   s;
  logic                    fb;
  logic [OUTPUT_WIDTH-1:0] raw;
  logic [OUTPUT_WIDTH-1:0] word;

  // Unroll OUTPUT_WIDTH LFSR steps and form the output word; hold when idle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    s       = state_q;
    fb      = 1'b0;
    raw     = '0;
    word    = '0;

    for (int i = 0; i < int'(OUTPUT_WIDTH); i++) begin
      if (IS_GALOIS) begin
        fb = s[LFSR_WIDTH-1];
        s  = {s[LFSR_WIDTH-2:0], 1'b0} ^ (fb ? LFSR_POLY : '0);
      end else begin
        if (USE_LOOP) begin
          fb = s[LFSR_WIDTH-1];
          for (int j = 1; j < int'(LFSR_WIDTH); j++) begin
            if (LFSR_POLY[j]) begin
              fb = fb ^ s[j-1];
            end
          end
        end else begin
          fb = s[LFSR_WIDTH-1] ^ (^(s & FIB_TAPS));
        end
        s = {s[LFSR_WIDTH-2:0], fb};
      end
      // First generated bit lands in the MSB.
      raw[OUTPUT_WIDTH-1-i] = fb;
    end

    if (REVERSE) begin
      for (int i = 0; i < int'(OUTPUT_WIDTH); i++) begin
        word[i] = raw[OUTPUT_WIDTH-1-i];
      end
    end else begin
      word = raw;
    end

    if (INVERT) begin
      word = ~word;
    end

    if (enable) begin
      state_d = s;
      data_d  = word;
    end
  end

  // State and output registers; reset value of the word is plain zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LFSR_INIT;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Scoreboard bench for lfsr_prbs_gen: several configurations share clk, rst
// and enable; a bit-serial model predicts each word, a monitor compares.
module tb_lfsr_prbs_gen;

  localparam int NID = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;

  logic [7:0]  o_v1, o_inv, o_rev, o_gal9, o_def, o_g31, o_zero;
  logic [19:0] o_wide;

  always #5 clk = ~clk;

  // PRBS9 Fibonacci, plain word
  lfsr_prbs_gen #(.LFSR_WIDTH(9), .LFSR_POLY(9'h021), .LFSR_INIT(9'h1FF),
    .LFSR_CONFIG("FIBONACCI"), .REVERSE(1'b0), .INVERT(1'b0),
    .OUTPUT_WIDTH(8), .STYLE("AUTO"))
    u_v1 (.clk(clk), .rst(rst), .enable(enable), .data_out(o_v1));

  // PRBS9 Fibonacci, inverted
  lfsr_prbs_gen #(.LFSR_WIDTH(9), .LFSR_POLY(9'h021), .LFSR_INIT(9'h1FF),
    .LFSR_CONFIG("FIBONACCI"), .REVERSE(1'b0), .INVERT(1'b1),
    .OUTPUT_WIDTH(8), .STYLE("AUTO"))
    u_inv (.clk(clk), .rst(rst), .enable(enable), .data_out(o_inv));

  // PRBS9 Fibonacci, reversed
  lfsr_prbs_gen #(.LFSR_WIDTH(9), .LFSR_POLY(9'h021), .LFSR_INIT(9'h1FF),
    .LFSR_CONFIG("FIBONACCI"), .REVERSE(1'b1), .INVERT(1'b0),
    .OUTPUT_WIDTH(8), .STYLE("AUTO"))
    u_rev (.clk(clk), .rst(rst), .enable(enable), .data_out(o_rev));

  // PRBS9 Galois
  lfsr_prbs_gen #(.LFSR_WIDTH(9), .LFSR_POLY(9'h021), .LFSR_INIT(9'h1FF),
    .LFSR_CONFIG("GALOIS"), .REVERSE(1'b0), .INVERT(1'b0),
    .OUTPUT_WIDTH(8), .STYLE("REDUCTION"))
    u_gal9 (.clk(clk), .rst(rst), .enable(enable), .data_out(o_gal9));

  // All defaults: PRBS31 Fibonacci, inverted
  lfsr_prbs_gen u_def (.clk(clk), .rst(rst), .enable(enable), .data_out(o_def));

  // PRBS31 Galois, other defaults
  lfsr_prbs_gen #(.LFSR_CONFIG("GALOIS"))
    u_g31 (.clk(clk), .rst(rst), .enable(enable), .data_out(o_g31));

  // Word wider than the state, reversed and inverted, loop style
  lfsr_prbs_gen #(.LFSR_WIDTH(9), .LFSR_POLY(9'h021), .LFSR_INIT(9'h1FF),
    .LFSR_CONFIG("FIBONACCI"), .REVERSE(1'b1), .INVERT(1'b1),
    .OUTPUT_WIDTH(20), .STYLE("LOOP"))
    u_wide (.clk(clk), .rst(rst), .enable(enable), .data_out(o_wide));

  // Zero seed: locked-up Fibonacci register
  lfsr_prbs_gen #(.LFSR_WIDTH(9), .LFSR_POLY(9'h021), .LFSR_INIT(9'h000),
    .LFSR_CONFIG("FIBONACCI"), .REVERSE(1'b0), .INVERT(1'b0),
    .OUTPUT_WIDTH(8), .STYLE("AUTO"))
    u_zero (.clk(clk), .rst(rst), .enable(enable), .data_out(o_zero));

  // Reference configuration per instance id
  int     cfg_w    [NID];
  longint cfg_poly [NID];
  longint cfg_init [NID];
  int     cfg_ow   [NID];
  bit     cfg_gal  [NID];
  bit     cfg_rev  [NID];
  bit     cfg_inv  [NID];

  // Model state: register contents and last expected data_out
  longint st   [NID];
  longint dout [NID];
  int     word_cnt;

  longint exp_q[$];
  longint kat_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic set_cfg(input int id, input int w, input longint poly,
                         input longint init, input int ow, input bit gal,
                         input bit rev, input bit inv);
    cfg_w[id] = w; cfg_poly[id] = poly; cfg_init[id] = init;
    cfg_ow[id] = ow; cfg_gal[id] = gal; cfg_rev[id] = rev; cfg_inv[id] = inv;
  endtask

  function automatic longint act(input int id);
    case (id)
      0: return longint'(o_v1);
      1: return longint'(o_inv);
      2: return longint'(o_rev);
      3: return longint'(o_gal9);
      4: return longint'(o_def);
      5: return longint'(o_g31);
      6: return longint'(o_wide);
      default: return longint'(o_zero);
    endcase
  endfunction

  // Bit-serial generation of one word from the step rules, then formatting.
  function automatic longint model_word(input int id);
    longint mask = (longint'(1) << cfg_w[id]) - 1;
    longint w = 0;
    longint rv = 0;
    bit     b;
    int     p;
    for (int i = 0; i < cfg_ow[id]; i++) begin
      if (cfg_gal[id]) begin
        b = st[id][cfg_w[id]-1];
        st[id] = ((st[id] << 1) & mask) ^ (b ? cfg_poly[id] : longint'(0));
      end else begin
        p = $countones(st[id] & (cfg_poly[id] >> 1));
        b = st[id][cfg_w[id]-1] ^ p[0];
        st[id] = ((st[id] << 1) | longint'(b)) & mask;
      end
      w = (w << 1) | longint'(b);
    end
    if (cfg_rev[id]) begin
      for (int i = 0; i < cfg_ow[id]; i++) begin
        if (w[i]) rv[cfg_ow[id]-1-i] = 1'b1;
      end
      w = rv;
    end
    if (cfg_inv[id]) w = ~w & ((longint'(1) << cfg_ow[id]) - 1);
    return w;
  endfunction

  task automatic check(input string name, input longint a, input longint e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, a, e, $time);
    end
  endtask

  // One cycle of stimulus, set up between edges; pushes the prediction.
  task automatic drive(input bit r, input bit e, input bit chk_async);
    longint k0 = -1, k1 = -1, k2 = -1;
    @(negedge clk);
    rst = r;
    enable = e;
    if (r) begin
      for (int id = 0; id < NID; id++) begin
        st[id] = cfg_init[id];
        dout[id] = 0;
      end
      word_cnt = 0;
      k0 = 0; k1 = 0; k2 = 0;
    end else if (e) begin
      for (int id = 0; id < NID; id++) dout[id] = model_word(id);
      word_cnt++;
      case (word_cnt)
        1:   begin k0 = 64'h07; k1 = 64'hF8; k2 = 64'hE0; end
        2:   k0 = 64'hBE;
        3:   k0 = 64'h2E;
        512: k0 = 64'h07;
        default: ;
      endcase
    end
    for (int id = 0; id < NID; id++) exp_q.push_back(dout[id]);
    kat_q.push_back(k0);
    kat_q.push_back(k1);
    kat_q.push_back(k2);
    if (chk_async) begin
      #1;
      for (int id = 0; id < NID; id++)
        check($sformatf("async_rst id%0d", id), act(id), 0);
    end
  endtask

  // Monitor: after every rising edge, compare all outputs with predictions.
  initial begin
    longint e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() >= NID) begin
        for (int id = 0; id < NID; id++) begin
          e = exp_q.pop_front();
          check($sformatf("model id%0d", id), act(id), e);
        end
        for (int k = 0; k < 3; k++) begin
          e = kat_q.pop_front();
          if (e >= 0) check($sformatf("known_word id%0d w%0d", k, word_cnt), act(k), e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_cfg(0, 9,  64'h021,      64'h1FF,      8,  1'b0, 1'b0, 1'b0);
    set_cfg(1, 9,  64'h021,      64'h1FF,      8,  1'b0, 1'b0, 1'b1);
    set_cfg(2, 9,  64'h021,      64'h1FF,      8,  1'b0, 1'b1, 1'b0);
    set_cfg(3, 9,  64'h021,      64'h1FF,      8,  1'b1, 1'b0, 1'b0);
    set_cfg(4, 31, 64'h10000001, 64'h7FFFFFFF, 8,  1'b0, 1'b0, 1'b1);
    set_cfg(5, 31, 64'h10000001, 64'h7FFFFFFF, 8,  1'b1, 1'b0, 1'b1);
    set_cfg(6, 9,  64'h021,      64'h1FF,      20, 1'b0, 1'b1, 1'b1);
    set_cfg(7, 9,  64'h021,      64'h000,      8,  1'b0, 1'b0, 1'b0);
    for (int id = 0; id < NID; id++) begin
      st[id] = cfg_init[id];
      dout[id] = 0;
    end
    word_cnt = 0;

    // Reset held, enable ignored
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    // Free-running words straight after release
    repeat (4) drive(1'b0, 1'b1, 1'b0);

    // Enable pulsed once every third cycle
    drive(1'b1, 1'b0, 1'b1);
    for (int p = 0; p < 4; p++) begin
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end

    // Full PRBS9 period and wrap
    drive(1'b1, 1'b0, 1'b1);
    repeat (515) drive(1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-run, then restart
    drive(1'b1, 1'b0, 1'b1);
    repeat (5) drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b1, 1'b0);

    // Random enable with occasional resets
    for (int c = 0; c < 1000; c++) begin
      bit r, e;
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 3) != 0);
      drive(r, e, r);
    end

    repeat (2) @(posedge clk);
    #4;
    check("scoreboard_drained", longint'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_prbs_gen.md
LFSR_PRBS_GEN -- requirements
Module: lfsr_prbs_gen

Interface
REQ-001 Parameter LFSR_WIDTH, default 31: LFSR state width in bits, 2 or more.
REQ-002 Parameter LFSR_POLY, default 31'h10000001: feedback polynomial; bit j set means x^j term, the x^LFSR_WIDTH term is implicit, and bit 0 is the constant term.
REQ-003 Parameter LFSR_INIT, default all ones (LFSR_WIDTH bits): state loaded on reset; a non-zero value is required.
REQ-004 Parameter LFSR_CONFIG, default "FIBONACCI": "FIBONACCI" or "GALOIS".
REQ-005 Parameter REVERSE, default 0: when 1, data_out is bit-reversed.
REQ-006 Parameter INVERT, default 1: when 1, data_out is bitwise inverted.
REQ-007 Parameter OUTPUT_WIDTH, default 8: number of PRBS bits produced per enabled cycle, 1 or more.
REQ-008 Parameter STYLE, default "AUTO": implementation hint ("AUTO", "LOOP" or "REDUCTION"); it SHALL have no functional effect.
REQ-009 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-010 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-011 Port enable, input, 1 bit: advance the generator by OUTPUT_WIDTH bits this cycle.
REQ-012 Port data_out, output, OUTPUT_WIDTH bits: registered PRBS word.

Function
REQ-013 The block SHALL hold an LFSR_WIDTH-bit state register s and an OUTPUT_WIDTH-bit output register driving data_out.
REQ-014 Fibonacci step: f = s[W-1] XOR (XOR of s[j-1] over all j in 1..W-1 with LFSR_POLY[j]=1); s_next = {s[W-2:0], f}; the step's output bit is f.
REQ-015 Galois step: o = s[W-1]; s_next = {s[W-2:0], 0} XOR (o ? LFSR_POLY : 0); the step's output bit is o.
REQ-016 On a rising clk edge with enable=1, the block SHALL apply OUTPUT_WIDTH consecutive steps combinationally from the current s, and load s with the resulting state.
REQ-017 On that same edge, the raw word r SHALL be the generated bits with the first-generated bit in r[OUTPUT_WIDTH-1] and the last-generated bit in r[0].
REQ-018 On that same edge, data_out SHALL load r, bit-reversed if REVERSE=1, then inverted if INVERT=1.
REQ-019 Latency: each word appears on data_out one clock after the enabled edge that computes it.
REQ-020 With enable=0, s and data_out SHALL hold their values.
REQ-021 The block SHALL NOT guard against an all-zero state; with a zero LFSR_INIT in Fibonacci mode the output stays constant.
REQ-022 OUTPUT_WIDTH SHALL be allowed to exceed LFSR_WIDTH, with no change to the step definition.

Reset
REQ-023 While rst=1, immediately and independently of clk: s = LFSR_INIT and data_out = 0 (no inversion is applied to the reset value).
REQ-024 An enabled word is produced on the first enabled rising edge after rst is deasserted; an edge with rst=1 produces no word.
REQ-025 Asserting rst mid-sequence SHALL discard the current state; the sequence restarts from LFSR_INIT.

Verification
All scenarios use LFSR_WIDTH=9, LFSR_POLY=9'h021, LFSR_CONFIG="FIBONACCI", OUTPUT_WIDTH=8, unless stated otherwise.
- V1 (PRBS9 basic): REVERSE=0, INVERT=0; reset, then enable held high -> data_out = 0x00 during reset, then 0x07, 0xBE, 0x2E on consecutive cycles.
- V2 (invert/reverse): as V1 with INVERT=1 -> first word 0xF8; with REVERSE=1, INVERT=0 -> first word 0xE0.
- V3 (enable gating): as V1, with enable pulsed high for one cycle every third cycle -> same sequence 0x07, 0xBE, 0x2E; data_out stable between pulses.
- V4 (period): as V1; run 511 enabled cycles -> the 512th word equals 0x07; the sequence from then on matches a bit-accurate model of x^9+x^5+1 throughout.
- V5 (async reset mid-run): assert rst between clock edges after 5 words -> data_out = 0 before the next edge; after release, words restart at 0x07.
- V6 (Galois / default config): LFSR_CONFIG="GALOIS" and the default 31-bit PRBS31 configuration -> every word matches a bit-serial reference model for 1000 cycles.
